// File: rtl/sequence_player_if.sv
// Bus bundle between the LFSR sequencer / player controls and the sequence_player game core.
`timescale 1ns/1ps
interface sequence_player_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 4
) ();
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              seq_done;
   logic              btn_valid;
   logic [DATA_W-1:0] btn_code;
   logic              clr;
   logic              disp_valid;
   logic [DATA_W-1:0] disp_code;
   logic [5:0]        round;
   logic              busy;
   logic              win;
   logic              fail;

   modport master (
      output wr_en, wr_addr, wr_data, seq_done, btn_valid, btn_code, clr,
      input  disp_valid, disp_code, round, busy, win, fail
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, seq_done, btn_valid, btn_code, clr,
      output disp_valid, disp_code, round, busy, win, fail
   );
endinterface

// File: rtl/sequence_player.sv
// Simon-style memory game: buffers the sequencer pattern, plays back a growing
// prefix on the display, then checks player button codes against it.
`timescale 1ns/1ps
module sequence_player #(
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned DATA_W      = 4,
   parameter int unsigned SHOW_CYCLES = 8,
   parameter int unsigned GAP_CYCLES  = 4,
   parameter int unsigned MAX_ROUND   = 32
) (
   input logic              clk,
   input logic              rst,
   sequence_player_if.slave bus
);

   localparam int unsigned DEPTH   = 1 << ADDR_W;
   localparam int unsigned RND_W   = 6;
   localparam int unsigned TMR_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHOW_ON,
      S_SHOW_GAP,
      S_INPUT,
      S_ROUND_OK,
      S_WIN,
      S_FAIL
   } state_t;

   state_t            state, state_n;
   logic [RND_W-1:0]  round_n;
   logic [ADDR_W-1:0] idx, idx_n;
   logic [TMR_W-1:0]  timer, timer_n;
   logic              last_c;
   logic [DATA_W-1:0] cur_c;
   logic [DATA_W-1:0] show_c;
   logic [DATA_W-1:0] mem [DEPTH];

   // Pattern buffer: only loadable while idle, never cleared by reset
   always_ff @(posedge clk) begin
      if (rst && state == S_IDLE && bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      last_c = (idx == ADDR_W'(bus.round - RND_W'(1)));
      cur_c  = mem[idx];
      // Forward a same-cycle write so the first displayed code is never stale
      if (state == S_IDLE && bus.wr_en && bus.wr_addr == idx_n) begin
         show_c = bus.wr_data;
      end else begin
         show_c = mem[idx_n];
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      round_n = bus.round;
      idx_n   = idx;
      timer_n = timer;
      case (state)
         S_IDLE: begin
            if (bus.seq_done) begin
               state_n = S_SHOW_ON;
               round_n = RND_W'(1);
               idx_n   = '0;
               timer_n = '0;
            end
         end
         S_SHOW_ON: begin
            if (timer == TMR_W'(SHOW_CYCLES - 1)) begin
               state_n = S_SHOW_GAP;
               timer_n = '0;
            end else begin
               timer_n = timer + TMR_W'(1);
            end
         end
         S_SHOW_GAP: begin
            if (timer == TMR_W'(GAP_CYCLES - 1)) begin
               timer_n = '0;
               if (last_c) begin
                  state_n = S_INPUT;
                  idx_n   = '0;
               end else begin
                  state_n = S_SHOW_ON;
                  idx_n   = idx + ADDR_W'(1);
               end
            end else begin
               timer_n = timer + TMR_W'(1);
            end
         end
         S_INPUT: begin
            if (bus.btn_valid) begin
               if (bus.btn_code != cur_c) begin
                  state_n = S_FAIL;
               end else if (last_c) begin
                  state_n = S_ROUND_OK;
               end else begin
                  idx_n = idx + ADDR_W'(1);
               end
            end
         end
         S_ROUND_OK: begin
            if (bus.round == RND_W'(MAX_ROUND)) begin
               state_n = S_WIN;
            end else begin
               state_n = S_SHOW_ON;
               round_n = bus.round + RND_W'(1);
               idx_n   = '0;
               timer_n = '0;
            end
         end
         S_WIN, S_FAIL: begin
            if (bus.clr) begin
               state_n = S_IDLE;
               round_n = '0;
               idx_n   = '0;
               timer_n = '0;
            end
         end
         default: begin
            state_n = S_IDLE;
            round_n = '0;
            idx_n   = '0;
            timer_n = '0;
         end
      endcase
   end

   // State and registered outputs, all derived from the next state
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= S_IDLE;
         idx            <= '0;
         timer          <= '0;
         bus.round      <= '0;
         bus.disp_valid <= 1'b0;
         bus.disp_code  <= '0;
         bus.busy       <= 1'b0;
         bus.win        <= 1'b0;
         bus.fail       <= 1'b0;
      end else begin
         state          <= state_n;
         idx            <= idx_n;
         timer          <= timer_n;
         bus.round      <= round_n;
         bus.disp_valid <= (state_n == S_SHOW_ON);
         bus.disp_code  <= (state_n == S_SHOW_ON) ? show_c : '0;
         bus.busy       <= (state_n != S_IDLE);
         bus.win        <= (state_n == S_WIN);
         bus.fail       <= (state_n == S_FAIL);
      end
   end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Downstream consumer of the LFSR sequencer; implements a Simon-style memory game.
- Captures the sequencer's 4-bit pattern stream into an internal 32x4 buffer.
- Plays back a growing prefix of the stored pattern on the display, then checks player button codes against it.
- Reports the round number and a sticky win or fail flag to the top-level game controller.

Parameters:
- ADDR_W, 5, buffer address width; depth is 2^ADDR_W entries.
- DATA_W, 4, width of each pattern code.
- SHOW_CYCLES, 8, cycles each code is displayed; must be ≥1.
- GAP_CYCLES, 4, blank cycles after each displayed code; must be ≥1.
- MAX_ROUND, 32, round number whose completion asserts win; must be ≤2^ADDR_W.

Ports:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-low.
- wr_en in 1: write strobe for the buffer from the sequencer.
- wr_addr in ADDR_W: buffer write address.
- wr_data in DATA_W: buffer write data.
- seq_done in 1: sequencer finish pulse; starts the game.
- btn_valid in 1: single-cycle pulse marking a player entry.
- btn_code in DATA_W: player entry code, qualified by btn_valid.
- clr in 1: returns the block from WIN or FAIL to IDLE.
- disp_valid out 1: display code is active.
- disp_code out DATA_W: code to display; 0 when disp_valid=0.
- round out 6: current round, 1..MAX_ROUND; 0 in IDLE.
- busy out 1: high in every state except IDLE.
- win out 1: sticky; high in WIN.
- fail out 1: sticky; high in FAIL.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge):
  - state=IDLE; round, idx and timer = 0.
  - All outputs 0.
  - Buffer contents are not cleared.
- Buffer: writes occur only in IDLE; wr_en in any other state is ignored. Reads are combinational from an internal array.
- States: IDLE, SHOW_ON, SHOW_GAP, INPUT, ROUND_OK, WIN, FAIL.
- IDLE:
  - seq_done=1 → SHOW_ON with round=1, idx=0, timer=0.
  - If wr_en and seq_done are high in the same cycle, the write completes first, then the transition happens.
- SHOW_ON:
  - disp_valid=1 and disp_code=buf[idx] for exactly SHOW_CYCLES cycles.
  - disp_valid first rises on the cycle after seq_done is sampled.
  - Then → SHOW_GAP with timer=0.
- SHOW_GAP:
  - disp_valid=0 and disp_code=0 for GAP_CYCLES cycles.
  - If idx==round-1 → INPUT with idx=0.
  - Otherwise idx++ and → SHOW_ON.
- INPUT, on btn_valid=1:
  - btn_code≠buf[idx] → FAIL.
  - Match and idx==round-1 → ROUND_OK.
  - Match otherwise → idx++.
  - btn_valid in any other state is ignored; no queuing.
- ROUND_OK (one cycle):
  - round==MAX_ROUND → WIN.
  - Otherwise round++, idx=0, → SHOW_ON.
- WIN / FAIL:
  - Flag held high; round frozen at its final value.
  - clr=1 → IDLE, clearing flags and round.
  - clr in any other state is ignored.
  - seq_done is ignored everywhere except IDLE.
- Width: round is 6 bits, so MAX_ROUND=32 is representable; idx is ADDR_W bits and never wraps because idx≤round-1≤31.
- Reset mid-play takes priority over all inputs and returns to IDLE in one cycle.

Test Plan:
- Load buf[0..3]=3,7,A,1 via wr_en, then pulse seq_done → disp_valid high 8 cycles with disp_code=3, low 4 cycles, then state INPUT with round=1 and busy=1.
- Round 1 btn 3 → round=2; playback shows 3 (8 on / 4 off) then 7 (8 on / 4 off); INPUT accepts 3,7 → round=3.
- Round 2 btn 3 then 9 (expected 7) → fail=1 the cycle after the bad press; round stays 2; clr → fail=0, round=0, busy=0.
- btn_valid pulsed during SHOW_ON and SHOW_GAP → ignored; the subsequent correct INPUT sequence still advances the round.
- MAX_ROUND=2 build, all entries correct → win=1 after the round-2 final press; seq_done while win=1 is ignored.
- rst=0 during SHOW_ON of round 3 → next cycle all outputs are 0; a wr_en during INPUT leaves the buffer unchanged, checked by replaying after clr and a new seq_done.
